// File: rtl/arb_stream_21.sv
// Two-input valid/ready round-robin stream arbiter with a one-entry registered output stage.
// Optional build macro ARB_FIXED_PRIO_EN selects fixed priority (A wins contention).
module arb_stream_21 #(
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [DATA_W-1:0] i_a_data,
   input  logic              i_a_valid,
   output logic              o_a_ready,
   input  logic [DATA_W-1:0] i_b_data,
   input  logic              i_b_valid,
   output logic              o_b_ready,
   output logic [DATA_W-1:0] o_y,
   output logic              o_sel,
   output logic              o_valid,
   input  logic              i_ready
);

   logic              last_grant_r;
   logic              load_en_s;
   logic              grant_a_s;
   logic              grant_b_s;
   logic [DATA_W-1:0] grant_data_s;

   // Output stage can take a new word when empty or being drained this cycle.
   assign load_en_s = ~o_valid | i_ready;

   // Grant selection: single requester wins outright, contention resolved by policy.
   always_comb begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
      if (i_a_valid && i_b_valid) begin
`ifdef ARB_FIXED_PRIO_EN
         grant_a_s = 1'b1;
`else
         // Serve the port that was not served last.
         if (last_grant_r) begin
            grant_a_s = 1'b1;
         end else begin
            grant_b_s = 1'b1;
         end
`endif
      end else if (i_a_valid) begin
         grant_a_s = 1'b1;
      end else if (i_b_valid) begin
         grant_b_s = 1'b1;
      end else begin
         grant_a_s = 1'b0;
         grant_b_s = 1'b0;
      end
   end

   // Data mux feeding the output register.
   always_comb begin
      grant_data_s = i_a_data;
      if (grant_b_s) begin
         grant_data_s = i_b_data;
      end else begin
         grant_data_s = i_a_data;
      end
   end

   // Readies are gated by reset so nothing is accepted while the stage is being cleared.
   always_comb begin
      o_a_ready = i_rst_n & load_en_s & grant_a_s;
      o_b_ready = i_rst_n & load_en_s & grant_b_s;
   end

   // Output register and round-robin history.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_y          <= {DATA_W{1'b0}};
         o_sel        <= 1'b0;
         o_valid      <= 1'b0;
         last_grant_r <= 1'b1;
      end else if (load_en_s) begin
         if (grant_a_s || grant_b_s) begin
            o_y          <= grant_data_s;
            o_sel        <= grant_b_s;
            o_valid      <= 1'b1;
            last_grant_r <= grant_b_s;
         end else begin
            o_valid      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arb_stream_21.sv
// Self-checking bench for arb_stream_21: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_arb_stream_21;

   logic       i_clk;
   logic       i_rst_n;
   logic [7:0] i_a_data;
   logic       i_a_valid;
   logic       o_a_ready;
   logic [7:0] i_b_data;
   logic       i_b_valid;
   logic       o_b_ready;
   logic [7:0] o_y;
   logic       o_sel;
   logic       o_valid;
   logic       i_ready;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   bit       m_valid;
   bit [7:0] m_y;
   bit       m_sel;
   bit       m_last;

   arb_stream_21 #(.DATA_W(8)) dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_a_data (i_a_data),
      .i_a_valid(i_a_valid),
      .o_a_ready(o_a_ready),
      .i_b_data (i_b_data),
      .i_b_valid(i_b_valid),
      .o_b_ready(o_b_ready),
      .o_y      (o_y),
      .o_sel    (o_sel),
      .o_valid  (o_valid),
      .i_ready  (i_ready)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

`ifdef ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   // -1 = nobody, 0 = A, 1 = B
   function automatic int exp_grant(bit av, bit bv, bit last);
      if (!av && !bv) return -1;
      if (av ^ bv) return av ? 0 : 1;
      if (FIXED) return 0;
      return last ? 0 : 1;
   endfunction

   function automatic bit exp_ready(int port);
      return i_rst_n && (!m_valid || i_ready) &&
             exp_grant(i_a_valid, i_b_valid, m_last) == port;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_y     = 8'h00;
      m_sel   = 1'b0;
      m_last  = 1'b1;
   endtask

   // Advance one clock edge, updating the model with the inputs seen at that edge.
   task automatic tick();
      int g;
      @(posedge i_clk);
      if (!i_rst_n) begin
         model_reset();
      end else if (!m_valid || i_ready) begin
         g = exp_grant(i_a_valid, i_b_valid, m_last);
         if (g >= 0) begin
            m_y     = (g == 0) ? i_a_data : i_b_data;
            m_sel   = (g == 1);
            m_valid = 1'b1;
            m_last  = (g == 1);
         end else begin
            m_valid = 1'b0;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      i_rst_n   = 1'b0;
      i_a_valid = 1'b0;
      i_b_valid = 1'b0;
      i_ready   = 1'b1;
      model_reset();
      tick();
      tick();
      i_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      i_rst_n   = 1'b0;
      i_a_valid = 1'b1;
      i_b_valid = 1'b1;
      i_a_data  = 8'h33;
      i_b_data  = 8'h44;
      i_ready   = 1'b1;
      model_reset();
      #2;
      n_tests++;
      if (o_valid !== 1'b0 || o_y !== 8'h00 || o_sel !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b y=%h sel=%b, want 0 00 0", o_valid, o_y, o_sel);
      end
      n_tests++;
      if (o_a_ready !== 1'b0 || o_b_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_readies: got a=%b b=%b, want 0 0", o_a_ready, o_b_ready);
      end
      tick();
      i_rst_n = 1'b1;
      #1;
      n_tests++;
      if (o_a_ready !== 1'b1 || o_b_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_first_accept: got a=%b b=%b, want 1 0", o_a_ready, o_b_ready);
      end
      tick();
      n_tests++;
      if (o_valid !== 1'b1 || o_y !== 8'h33 || o_sel !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_first_word: got valid=%b y=%h sel=%b, want 1 33 0", o_valid, o_y, o_sel);
      end
   endtask

   task automatic test_contention();
      bit       want_b;
      bit [7:0] want_y;
      do_reset();
      i_a_data  = 8'h11;
      i_b_data  = 8'h22;
      i_a_valid = 1'b1;
      i_b_valid = 1'b1;
      i_ready   = 1'b1;
      #1;
      n_tests++;
      if (o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL contention_first_cycle_valid: got %b want 0", o_valid);
      end
      for (int k = 0; k < 6; k++) begin
         want_b = FIXED ? 1'b0 : (k % 2 == 1);
         want_y = want_b ? 8'h22 : 8'h11;
         n_tests++;
         if (o_a_ready !== !want_b || o_b_ready !== want_b) begin
            n_fail++;
            $display("FAIL contention_ready[%0d]: got a=%b b=%b want a=%b b=%b",
                     k, o_a_ready, o_b_ready, !want_b, want_b);
         end
         tick();
         n_tests++;
         if (o_valid !== 1'b1 || o_y !== want_y || o_sel !== want_b) begin
            n_fail++;
            $display("FAIL contention_out[%0d]: got valid=%b y=%h sel=%b want 1 %h %b",
                     k, o_valid, o_y, o_sel, want_y, want_b);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      i_a_data  = 8'h11;
      i_b_data  = 8'h22;
      i_a_valid = 1'b1;
      i_b_valid = 1'b1;
      i_ready   = 1'b1;
      tick();
      i_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_tests++;
         if (o_a_ready !== 1'b0 || o_b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready[%0d]: got a=%b b=%b want 0 0", k, o_a_ready, o_b_ready);
         end
         tick();
         n_tests++;
         if (o_valid !== 1'b1 || o_y !== 8'h11 || o_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got valid=%b y=%h sel=%b want 1 11 0", k, o_valid, o_y, o_sel);
         end
      end
      i_ready = 1'b1;
      tick();
      n_tests++;
      if (o_y !== (FIXED ? 8'h11 : 8'h22) || o_sel !== !FIXED) begin
         n_fail++;
         $display("FAIL bp_release: got y=%h sel=%b want %h %b",
                  o_y, o_sel, FIXED ? 8'h11 : 8'h22, !FIXED);
      end
   endtask

   task automatic test_single_then_contention();
      do_reset();
      i_b_data  = 8'h5A;
      i_b_valid = 1'b1;
      i_a_valid = 1'b0;
      i_a_data  = 8'hA5;
      i_ready   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_tests++;
         if (o_a_ready !== 1'b0 || o_b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_b_ready[%0d]: got a=%b b=%b want 0 1", k, o_a_ready, o_b_ready);
         end
         tick();
         n_tests++;
         if (o_valid !== 1'b1 || o_y !== 8'h5A || o_sel !== 1'b1) begin
            n_fail++;
            $display("FAIL single_b_out[%0d]: got valid=%b y=%h sel=%b want 1 5a 1", k, o_valid, o_y, o_sel);
         end
      end
      i_a_valid = 1'b1;
      tick();
      n_tests++;
      if (o_y !== 8'hA5 || o_sel !== 1'b0) begin
         n_fail++;
         $display("FAIL join_a_first: got y=%h sel=%b want a5 0", o_y, o_sel);
      end
      tick();
      n_tests++;
      if (o_y !== (FIXED ? 8'hA5 : 8'h5A) || o_sel !== !FIXED) begin
         n_fail++;
         $display("FAIL join_then: got y=%h sel=%b want %h %b",
                  o_y, o_sel, FIXED ? 8'hA5 : 8'h5A, !FIXED);
      end
   endtask

   task automatic test_idle_reset();
      do_reset();
      i_a_data  = 8'h77;
      i_a_valid = 1'b1;
      i_ready   = 1'b1;
      tick();
      i_a_valid = 1'b0;
      i_b_valid = 1'b0;
      #1;
      n_tests++;
      if (o_a_ready !== 1'b0 || o_b_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ready: got a=%b b=%b want 0 0", o_a_ready, o_b_ready);
      end
      tick();
      n_tests++;
      if (o_valid !== 1'b0 || o_y !== 8'h77) begin
         n_fail++;
         $display("FAIL idle_drop: got valid=%b y=%h want 0 77", o_valid, o_y);
      end
      i_b_data  = 8'h99;
      i_b_valid = 1'b1;
      i_ready   = 1'b0;
      tick();
      #2;
      i_rst_n = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if (o_valid !== 1'b0 || o_y !== 8'h00 || o_a_ready !== 1'b0 || o_b_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got valid=%b y=%h a=%b b=%b want 0 00 0 0",
                  o_valid, o_y, o_a_ready, o_b_ready);
      end
      tick();
      i_rst_n = 1'b1;
   endtask

   task automatic test_random();
      bit       a_pend = 1'b0;
      bit       b_pend = 1'b0;
      bit       ea;
      bit       eb;
      int       a_acc = 0;
      int       b_acc = 0;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if (!a_pend && ($urandom % 3 != 0)) begin
            a_pend   = 1'b1;
            i_a_data = 8'($urandom);
         end
         if (!b_pend && ($urandom % 3 != 0)) begin
            b_pend   = 1'b1;
            i_b_data = 8'($urandom);
         end
         i_a_valid = a_pend;
         i_b_valid = b_pend;
         i_ready   = ($urandom % 4 != 0);
         if ($urandom % 97 == 0) begin
            i_rst_n = 1'b0;
            model_reset();
         end else begin
            i_rst_n = 1'b1;
         end
         #1;
         ea = exp_ready(0);
         eb = exp_ready(1);
         n_tests++;
         if (o_a_ready !== ea || o_b_ready !== eb) begin
            n_fail++;
            $display("FAIL rand_ready[%0d]: got a=%b b=%b want a=%b b=%b", c, o_a_ready, o_b_ready, ea, eb);
         end
         n_tests++;
         if (o_valid !== m_valid || (m_valid && (o_y !== m_y || o_sel !== m_sel))) begin
            n_fail++;
            $display("FAIL rand_out[%0d]: got valid=%b y=%h sel=%b want %b %h %b",
                     c, o_valid, o_y, o_sel, m_valid, m_y, m_sel);
         end
         tick();
         if (ea) begin
            a_pend = 1'b0;
            a_acc++;
         end
         if (eb) begin
            b_pend = 1'b0;
            b_acc++;
         end
      end
      i_rst_n = 1'b1;
      n_tests++;
      if (a_acc == 0 || (!FIXED && b_acc == 0)) begin
         n_fail++;
         $display("FAIL rand_progress: got a_acc=%0d b_acc=%0d want both nonzero", a_acc, b_acc);
      end
   endtask

   initial begin
      test_reset();
      test_contention();
      test_backpressure();
      test_single_then_contention();
      test_idle_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
